// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and constants for the DDR port arbiter slice.
// Provides FSM state encoding, default widths and requester index names.
package ap_ddr_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int DDR_ADDR_W_DEF = 28;
    localparam int DATA_W_DEF     = 16;
    localparam int LEN_W_DEF      = 10;

    localparam int REQ_ICACHE    = 0;
    localparam int REQ_DCACHE_LD = 1;
    localparam int REQ_DCACHE_ST = 2;
    localparam int REQ_JMP       = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RD   = S_RD,
        ST_WR   = S_WR,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// DDR burst interface between the arbiter (master) and DDR controller (slave).
// Carries read/write burst request, address, length, data and strobes.
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 10,
    parameter int DATA_W = 16
);
    logic              rd_burst_req;
    logic [ADDR_W-1:0] rd_burst_addr;
    logic [LEN_W-1:0]  rd_burst_len;
    logic              rd_burst_data_valid;
    logic              rd_burst_finish;
    logic              wr_burst_req;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic [LEN_W-1:0]  wr_burst_len;
    logic [DATA_W-1:0] wr_burst_data;
    logic              wr_burst_data_req;
    logic              wr_burst_finish;

    modport master (
        output rd_burst_req, rd_burst_addr, rd_burst_len,
        output wr_burst_req, wr_burst_addr, wr_burst_len,
        output wr_burst_data,
        input  rd_burst_data_valid, rd_burst_finish,
        input  wr_burst_data_req, wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_addr, rd_burst_len,
        input  wr_burst_req, wr_burst_addr, wr_burst_len,
        input  wr_burst_data,
        output rd_burst_data_valid, rd_burst_finish,
        output wr_burst_data_req, wr_burst_finish
    );
endinterface

// File: rtl/ddr_port_arbiter_arb_select.sv
// Combinational priority encoder: pending -> one-hot pick, index, any.
// With DDR_ARB_ROUND_ROBIN_EN the search starts at ptr, else at bit 0.
module arb_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pending,
`ifdef DDR_ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
            j = (int'(ptr) + i) % N;
`else
            j = i;
`endif
            if (!any && pending[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end
endmodule

// File: rtl/ddr_port_arbiter.sv
// Arbitrates N_REQ burst requesters onto one DDR burst interface.
// Ports: clk, rst (async high), req_rd/req_wr/req_addr/req_len/req_wdata in;
// gnt/done/rd_valid/wr_data_req/busy out; ddr = DDR master modport.
// Optional: define DDR_ARB_ROUND_ROBIN_EN for rotating priority.
module ddr_port_arbiter
    import ap_ddr_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int DDR_ADDR_WIDTH = DDR_ADDR_W_DEF,
    parameter int DATA_WIDTH     = DATA_W_DEF,
    parameter int LEN_WIDTH      = LEN_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_rd,
    input  logic [N_REQ-1:0]              req_wr,
    input  logic [N_REQ*DDR_ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*LEN_WIDTH-1:0]    req_len,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              done,
    output logic [N_REQ-1:0]              rd_valid,
    output logic [N_REQ-1:0]              wr_data_req,
    output logic                          busy,
    ddr_port_arbiter_if.master            ddr
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                    state;
    logic [IW-1:0]             idx_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [N_REQ-1:0]          gnt_q;
    logic [N_REQ-1:0]          done_q;
    logic                      rd_req_q;
    logic                      wr_req_q;

    logic [N_REQ-1:0]          sel_oh;
    logic [IW-1:0]             sel_idx;
    logic                      sel_any;
    logic [LEN_WIDTH-1:0]      sel_len;
    logic [DDR_ADDR_WIDTH-1:0] sel_addr;

`ifdef DDR_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_nxt;

    // Next search start is one past the requester being completed.
    assign ptr_nxt = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif

    arb_select #(
        .N  (N_REQ),
        .IW (IW)
    ) u_sel (
        .pending (req_rd | req_wr),
`ifdef DDR_ARB_ROUND_ROBIN_EN
        .ptr     (ptr_q),
`endif
        .onehot  (sel_oh),
        .idx     (sel_idx),
        .any     (sel_any)
    );

    assign sel_len  = req_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
    assign sel_addr = req_addr[sel_idx*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            done_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        idx_q  <= sel_idx;
                        addr_q <= sel_addr;
                        len_q  <= sel_len;
                        if (sel_len == '0) begin
                            // Empty burst: complete without touching DDR.
                            state  <= ST_DONE;
                            done_q <= sel_oh;
`ifdef DDR_ARB_ROUND_ROBIN_EN
                            ptr_q  <= (sel_idx == IW'(N_REQ - 1)) ?
                                      '0 : sel_idx + 1'b1;
`endif
                        end else begin
                            gnt_q <= sel_oh;
                            // Read wins when both are raised.
                            if (req_rd[sel_idx]) begin
                                state    <= ST_RD;
                                rd_req_q <= 1'b1;
                            end else begin
                                state    <= ST_WR;
                                wr_req_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (ddr.rd_burst_finish) begin
                        state    <= ST_DONE;
                        rd_req_q <= 1'b0;
                        gnt_q    <= '0;
                        done_q   <= gnt_q;
`ifdef DDR_ARB_ROUND_ROBIN_EN
                        ptr_q    <= ptr_nxt;
`endif
                    end
                end
                ST_WR: begin
                    if (ddr.wr_burst_finish) begin
                        state    <= ST_DONE;
                        wr_req_q <= 1'b0;
                        gnt_q    <= '0;
                        done_q   <= gnt_q;
`ifdef DDR_ARB_ROUND_ROBIN_EN
                        ptr_q    <= ptr_nxt;
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state != ST_IDLE);

    // Strobes are steered by the held one-hot grant.
    assign rd_valid = (state == ST_RD && ddr.rd_burst_data_valid) ?
                      gnt_q : '0;
    assign wr_data_req = (state == ST_WR && ddr.wr_burst_data_req) ?
                         gnt_q : '0;

    assign ddr.rd_burst_req  = rd_req_q;
    assign ddr.rd_burst_addr = addr_q;
    assign ddr.rd_burst_len  = len_q;
    assign ddr.wr_burst_req  = wr_req_q;
    assign ddr.wr_burst_addr = addr_q;
    assign ddr.wr_burst_len  = len_q;
    assign ddr.wr_burst_data = (state == ST_WR) ?
        req_wdata[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed self-checking bench for ddr_port_arbiter.
// The bench plays the DDR controller side through the interface.
module tb_ddr_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int DW = 16;
    localparam int LW = 10;

`ifdef DDR_ARB_ROUND_ROBIN_EN
    localparam int FIRST3  = 3;
    localparam int SECOND3 = 0;
`else
    localparam int FIRST3  = 0;
    localparam int SECOND3 = 3;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_rd;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    wr_data_req;
    logic            busy;

    int checks = 0;
    int errors = 0;

    ddr_port_arbiter_if #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) ddr ();

    ddr_port_arbiter #(
        .N_REQ          (N),
        .DDR_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rd_valid    (rd_valid),
        .wr_data_req (wr_data_req),
        .busy        (busy),
        .ddr         (ddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_rd = '0;
        req_wr = '0;
        req_addr = '0;
        req_len = '0;
        req_wdata = '0;
        ddr.rd_burst_data_valid = 1'b0;
        ddr.rd_burst_finish = 1'b0;
        ddr.wr_burst_data_req = 1'b0;
        ddr.wr_burst_finish = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdreq", 32'(ddr.rd_burst_req), 32'h0);
        chk("rst_wrreq", 32'(ddr.wr_burst_req), 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // Idle: stray finish pulse must not produce done.
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("idle_fin_done", 32'(done), 32'h0);
        chk("idle_fin_busy", 32'(busy), 32'h0);

        // Read burst on requester 1.
        req_addr[1*AW +: AW] = 28'h0028000;
        req_len[1*LW +: LW] = 10'd16;
        req_rd = 4'b0010;
        step();
        chk("rd1_gnt", 32'(gnt), 32'h2);
        chk("rd1_req", 32'(ddr.rd_burst_req), 32'h1);
        chk("rd1_addr", 32'(ddr.rd_burst_addr), 32'h28000);
        chk("rd1_len", 32'(ddr.rd_burst_len), 32'd16);
        chk("rd1_busy", 32'(busy), 32'h1);
        chk("rd1_noval", 32'(rd_valid), 32'h0);
        req_addr[1*AW +: AW] = 28'h0FFFFFF;
        req_len[1*LW +: LW] = 10'd3;
        for (int i = 0; i < 16; i++) begin
            ddr.rd_burst_data_valid = 1'b1;
            #1;
            chk("rd1_valid", 32'(rd_valid), 32'h2);
            step();
            ddr.rd_burst_data_valid = 1'b0;
        end
        chk("rd1_addr_held", 32'(ddr.rd_burst_addr), 32'h28000);
        chk("rd1_len_held", 32'(ddr.rd_burst_len), 32'd16);
        ddr.wr_burst_finish = 1'b1;
        step();
        ddr.wr_burst_finish = 1'b0;
        chk("spur_gnt", 32'(gnt), 32'h2);
        chk("spur_rdreq", 32'(ddr.rd_burst_req), 32'h1);
        chk("spur_done", 32'(done), 32'h0);
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("rd1_done", 32'(done), 32'h2);
        chk("rd1_gnt_clr", 32'(gnt), 32'h0);
        chk("rd1_req_clr", 32'(ddr.rd_burst_req), 32'h0);
        req_rd = '0;
        step();
        chk("rd1_done_pulse", 32'(done), 32'h0);
        chk("rd1_idle", 32'(busy), 32'h0);

        // Write burst on requester 2.
        req_addr[2*AW +: AW] = 28'h0001000;
        req_len[2*LW +: LW] = 10'd16;
        req_wdata[2*DW +: DW] = 16'hA5A5;
        req_wdata[1*DW +: DW] = 16'h1234;
        req_wr = 4'b0100;
        step();
        chk("wr2_gnt", 32'(gnt), 32'h4);
        chk("wr2_req", 32'(ddr.wr_burst_req), 32'h1);
        chk("wr2_rdreq", 32'(ddr.rd_burst_req), 32'h0);
        chk("wr2_addr", 32'(ddr.wr_burst_addr), 32'h1000);
        chk("wr2_len", 32'(ddr.wr_burst_len), 32'd16);
        ddr.rd_burst_data_valid = 1'b1;
        #1;
        chk("wr2_rdval_blk", 32'(rd_valid), 32'h0);
        ddr.rd_burst_data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ddr.wr_burst_data_req = 1'b1;
            #1;
            chk("wr2_data", 32'(ddr.wr_burst_data), 32'hA5A5);
            chk("wr2_dreq", 32'(wr_data_req), 32'h4);
            step();
            ddr.wr_burst_data_req = 1'b0;
        end
        ddr.wr_burst_finish = 1'b1;
        step();
        ddr.wr_burst_finish = 1'b0;
        chk("wr2_done", 32'(done), 32'h4);
        chk("wr2_wrreq_clr", 32'(ddr.wr_burst_req), 32'h0);
        chk("wr2_data_idle", 32'(ddr.wr_burst_data), 32'h0);
        req_wr = '0;
        step();

        // Requesters 0 and 3 together.
        req_len[0*LW +: LW] = 10'd4;
        req_len[3*LW +: LW] = 10'd4;
        req_rd = 4'b1001;
        step();
        chk("pri_first", 32'(gnt), 32'(1 << FIRST3));
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("pri_done1", 32'(done), 32'(1 << FIRST3));
        req_rd[FIRST3] = 1'b0;
        step();
        chk("pri_idle", 32'(gnt), 32'h0);
        step();
        chk("pri_second", 32'(gnt), 32'(1 << SECOND3));
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("pri_done2", 32'(done), 32'(1 << SECOND3));
        req_rd = '0;
        step();

        // Zero-length request on requester 3.
        req_len[3*LW +: LW] = 10'd0;
        req_rd = 4'b1000;
        step();
        chk("zl_done", 32'(done), 32'h8);
        chk("zl_rdreq", 32'(ddr.rd_burst_req), 32'h0);
        chk("zl_wrreq", 32'(ddr.wr_burst_req), 32'h0);
        chk("zl_gnt", 32'(gnt), 32'h0);
        req_rd = '0;
        step();
        chk("zl_done_clr", 32'(done), 32'h0);
        chk("zl_rdreq2", 32'(ddr.rd_burst_req), 32'h0);

        // Reset in the middle of a read burst.
        req_len[1*LW +: LW] = 10'd16;
        req_addr[1*AW +: AW] = 28'h0028000;
        req_rd = 4'b0010;
        step();
        for (int i = 0; i < 5; i++) begin
            ddr.rd_burst_data_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_rdreq", 32'(ddr.rd_burst_req), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_rdval", 32'(rd_valid), 32'h0);
        ddr.rd_burst_data_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("ar_regnt", 32'(gnt), 32'h2);
        chk("ar_rereq", 32'(ddr.rd_burst_req), 32'h1);
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("ar_done", 32'(done), 32'h2);
        req_rd = '0;
        step();

        // Read and write together on requester 1: read first.
        req_rd = 4'b0010;
        req_wr = 4'b0010;
        step();
        chk("rw_rdfirst", 32'(ddr.rd_burst_req), 32'h1);
        chk("rw_nowr", 32'(ddr.wr_burst_req), 32'h0);
        ddr.rd_burst_finish = 1'b1;
        step();
        ddr.rd_burst_finish = 1'b0;
        chk("rw_done_rd", 32'(done), 32'h2);
        req_rd = '0;
        step();
        step();
        chk("rw_wr_gnt", 32'(gnt), 32'h2);
        chk("rw_wr_req", 32'(ddr.wr_burst_req), 32'h1);
        chk("rw_wr_data", 32'(ddr.wr_burst_data), 32'h1234);
        ddr.wr_burst_finish = 1'b1;
        step();
        ddr.wr_burst_finish = 1'b0;
        chk("rw_done_wr", 32'(done), 32'h2);
        req_wr = '0;
        step();
        chk("end_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
